// File: rtl/mem_stage_pipe.sv
// EX/MEM pipeline register with a req/ack data-memory access controller.
// Freezes upstream stages via StallMem until each access acks or times out.
module mem_stage_pipe #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ValidE,
   input  logic              RegWriteE,
   input  logic              MemtoRegE,
   input  logic              MemWriteE,
   input  logic [DATA_W-1:0] ALUOutE,
   input  logic [DATA_W-1:0] WriteDataE,
   input  logic [REG_W-1:0]  WriteRegE,
   input  logic              FlushM,
   output logic              ValidM,
   output logic              RegWriteM,
   output logic              MemtoRegM,
   output logic              MemWriteM,
   output logic [DATA_W-1:0] ALUOutM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [REG_W-1:0]  WriteRegM,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              MemErrM,
   output logic              StallMem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_valid, r_rw, r_mtr, r_mw, r_err;
   logic [DATA_W-1:0] r_alu, r_wd, r_rdata;
   logic [REG_W-1:0]  r_wr;

   logic w_memop, w_stall;

   assign w_memop = r_valid & (r_mtr | r_mw);
   // DONE releases the stall for exactly one cycle so the next instruction loads.
   assign w_stall = w_memop & (r_state != DONE);

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_rw    <= 1'b0;
         r_mtr   <= 1'b0;
         r_mw    <= 1'b0;
         r_alu   <= '0;
         r_wd    <= '0;
         r_wr    <= '0;
      end else if (!w_stall) begin
         r_alu <= ALUOutE;
         r_wd  <= WriteDataE;
         r_wr  <= WriteRegE;
         if (FlushM) begin
            r_valid <= 1'b0;
            r_rw    <= 1'b0;
            r_mtr   <= 1'b0;
            r_mw    <= 1'b0;
         end else begin
            r_valid <= ValidE;
            r_rw    <= RegWriteE;
            r_mtr   <= MemtoRegE;
            r_mw    <= MemWriteE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         if (!w_stall) r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_memop) begin
                  r_state <= BUSY;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // Ack has priority over a timeout landing on the same cycle.
               if (mem_ack) begin
                  r_state <= DONE;
                  if (r_mtr) r_rdata <= mem_rdata;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_state <= DONE;
                  r_err   <= 1'b1;
                  if (r_mtr) r_rdata <= '0;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ValidM     = r_valid;
   assign RegWriteM  = r_rw;
   assign MemtoRegM  = r_mtr;
   assign MemWriteM  = r_mw;
   assign ALUOutM    = r_alu;
   assign WriteDataM = r_wd;
   assign WriteRegM  = r_wr;
   assign ReadDataM  = r_rdata;
   assign MemErrM    = r_err;
   assign StallMem   = w_stall;
   assign mem_req    = (r_state == BUSY);
   assign mem_we     = r_mw;
   assign mem_addr   = r_alu;
   assign mem_wdata  = r_wd;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Self-checking bench for mem_stage_pipe: directed cases then random traffic
// scored against an occupancy/latency model of the M stage.
module tb_mem_stage_pipe;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ValidE, RegWriteE, MemtoRegE, MemWriteE, FlushM;
   logic [DW-1:0] ALUOutE, WriteDataE;
   logic [RW-1:0] WriteRegE;
   logic          ValidM, RegWriteM, MemtoRegM, MemWriteM;
   logic [DW-1:0] ALUOutM, WriteDataM, ReadDataM;
   logic [RW-1:0] WriteRegM;
   logic          MemErrM, StallMem, mem_req, mem_we, mem_ack;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] model_rd;

   mem_stage_pipe #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ValidE     (ValidE),
      .RegWriteE  (RegWriteE),
      .MemtoRegE  (MemtoRegE),
      .MemWriteE  (MemWriteE),
      .ALUOutE    (ALUOutE),
      .WriteDataE (WriteDataE),
      .WriteRegE  (WriteRegE),
      .FlushM     (FlushM),
      .ValidM     (ValidM),
      .RegWriteM  (RegWriteM),
      .MemtoRegM  (MemtoRegM),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .WriteRegM  (WriteRegM),
      .ReadDataM  (ReadDataM),
      .MemErrM    (MemErrM),
      .StallMem   (StallMem),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
         $error("comparison %s", tag);
      end
   endtask

   // Presents one EX instruction, lets it load, plays the memory with an ack on
   // BUSY cycle ack_at (none if ack_at > TO), and scores the whole M occupancy.
   task automatic issue(input logic v, input logic rw, input logic mtr, input logic mw,
                        input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                        input logic [RW-1:0] wr, input logic fl,
                        input int ack_at, input logic [DW-1:0] rd);
      logic ev, erw, emtr, emw, memop;
      int   busy, stall, req;
      ValidE = v; RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw;
      ALUOutE = alu; WriteDataE = wd; WriteRegE = wr; FlushM = fl;
      @(posedge clk); #1;
      FlushM = 1'b0;
      ev    = v & ~fl;
      erw   = rw & ~fl;
      emtr  = mtr & ~fl;
      emw   = mw & ~fl;
      memop = ev & (emtr | emw);
      busy  = !memop ? 0 : (ack_at <= TO) ? ack_at : TO;

      check("ld_valid", ValidM, ev);
      check("ld_regwrite", RegWriteM, erw);
      check("ld_memtoreg", MemtoRegM, emtr);
      check("ld_memwrite", MemWriteM, emw);
      check("ld_aluout", ALUOutM, alu);
      check("ld_wdata", WriteDataM, wd);
      check("ld_wreg", WriteRegM, wr);
      check("ld_err_clr", MemErrM, 1'b0);
      check("ld_req_low", mem_req, 1'b0);

      stall = 0;
      req   = 0;
      for (int c = 0; c < 20; c++) begin
         if (!StallMem) break;
         stall++;
         if (mem_req) begin
            req++;
            if (req == 1) begin
               check("req_addr", mem_addr, alu);
               check("req_we", mem_we, emw);
               check("req_wdata", mem_wdata, wd);
            end
            mem_ack   = (req == ack_at);
            mem_rdata = (req == ack_at) ? rd : DW'($urandom);
         end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = DW'($urandom);
         end
         FlushM = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      FlushM  = 1'b0;

      if (memop && emtr) model_rd = (ack_at <= TO) ? rd : '0;
      check("stall_cycles", stall, memop ? 1 + busy : 0);
      check("req_cycles", req, busy);
      check("done_req_low", mem_req, 1'b0);
      check("done_err", MemErrM, memop && (ack_at > TO));
      check("done_rdata", ReadDataM, model_rd);
      check("held_valid", ValidM, ev);
      check("held_aluout", ALUOutM, alu);
   endtask

   initial begin
      rst_n = 1'b0;
      ValidE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; FlushM = 0;
      ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
      mem_ack = 0; mem_rdata = '0;
      model_rd = '0;
      #12;
      check("rst_valid", ValidM, 1'b0);
      check("rst_regwrite", RegWriteM, 1'b0);
      check("rst_aluout", ALUOutM, '0);
      check("rst_rdata", ReadDataM, '0);
      check("rst_err", MemErrM, 1'b0);
      check("rst_stall", StallMem, 1'b0);
      check("rst_req", mem_req, 1'b0);
      rst_n = 1'b1;

      // ALU op, load acked on BUSY 2, store acked on BUSY 1
      issue(1, 1, 0, 0, 32'h0000_002A, 32'h0, 5'd5, 0, 1, 32'h0);
      issue(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd7, 0, 2, 32'hDEAD_BEEF);
      issue(1, 0, 0, 1, 32'h0000_0200, 32'h1234_5678, 5'd0, 0, 1, 32'h0);
      // timeout, then ack exactly on the last allowed BUSY cycle
      issue(1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd3, 0, 99, 32'h5555_5555);
      issue(1, 1, 1, 0, 32'h0000_0304, 32'h0, 5'd3, 0, TO, 32'hCAFE_F00D);
      // flushed store never requests; back-to-back loads
      issue(1, 1, 0, 1, 32'h0000_0400, 32'h0000_0009, 5'd2, 1, 1, 32'h0);
      issue(1, 1, 1, 0, 32'h0000_0500, 32'h0, 5'd9, 0, 1, 32'h0BAD_F00D);
      issue(1, 1, 1, 0, 32'h0000_0504, 32'h0, 5'd10, 0, 3, 32'h1357_9BDF);

      // asynchronous reset while BUSY
      ValidE = 1; RegWriteE = 1; MemtoRegE = 1; MemWriteE = 0;
      ALUOutE = 32'h600; WriteRegE = 5'd4;
      @(posedge clk); #1;
      for (int c = 0; c < 5; c++) begin
         if (mem_req) break;
         @(posedge clk); #1;
      end
      check("pre_rst_req", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", mem_req, 1'b0);
      check("arst_stall", StallMem, 1'b0);
      check("arst_valid", ValidM, 1'b0);
      check("arst_err", MemErrM, 1'b0);
      model_rd = '0;
      ValidE = 0; RegWriteE = 0; MemtoRegE = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_req", mem_req, 1'b0);
      check("post_rst_stall", StallMem, 1'b0);
      issue(1, 0, 0, 1, 32'h0000_0700, 32'hA5A5_A5A5, 5'd1, 0, 1, 32'h0);

      for (int n = 0; n < 80; n++) begin
         issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               DW'($urandom), DW'($urandom), RW'($urandom),
               1'($urandom_range(0, 4) == 0), int'($urandom_range(1, TO + 2)),
               DW'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised EX/MEM pipeline register with an integrated data-memory access controller.
- Latches EX-stage results, inserts bubbles on flush, and drives a variable-latency req/ack data memory.
- Raises StallMem to freeze upstream stages until each access completes, and flags an error if an access times out.
- Sits between the execute stage and the writeback pipeline register.

Parameters:
- DATA_W, 32, width of ALU result, store data, memory address and read data
- REG_W, 5, width of destination register index
- TIMEOUT, 16, maximum BUSY cycles awaiting mem_ack before abort (minimum 2)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ValidE  in  1  EX instruction is real (not a bubble)
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  EX control bits
- ALUOutE  in  DATA_W  EX result / memory address
- WriteDataE  in  DATA_W  store data
- WriteRegE  in  REG_W  destination register
- FlushM  in  1  turn the instruction being loaded into a bubble
- ValidM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered controls
- ALUOutM, WriteDataM  out  DATA_W  registered data
- WriteRegM  out  REG_W  registered destination
- ReadDataM  out  DATA_W  captured load data
- MemErrM  out  1  current M instruction's access timed out
- StallMem  out  1  hold all upstream stages this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write enable (= MemWriteM, meaningful only with mem_req)
- mem_addr  out  DATA_W  = ALUOutM
- mem_wdata  out  DATA_W  = WriteDataM
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  DATA_W  load data, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs are 0.
  - FSM is IDLE and the timeout counter is 0.
  - Consequently mem_req=0 and StallMem=0.
- memop = ValidM & (MemtoRegM | MemWriteM).
- StallMem = memop & (state != DONE). Combinational from registered state only.
- M register load:
  - Loads on each rising edge when StallMem=0; holds otherwise.
  - On a load with FlushM=1: ValidM, RegWriteM, MemtoRegM and MemWriteM all go to 0; data fields load normally.
  - On a load with FlushM=0: all fields take their E values and ValidM=ValidE.
  - FlushM has no effect while StallMem=1; an in-flight access is never aborted by flush.
- MemErrM: cleared on every load; set only by timeout.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if memop, go to BUSY and clear the counter; otherwise stay.
  - BUSY: mem_req=1 and the counter increments each cycle.
    - If mem_ack: go to DONE; if MemtoRegM, ReadDataM <= mem_rdata.
    - Else if counter == TIMEOUT-1: go to DONE, MemErrM <= 1, ReadDataM <= 0 if MemtoRegM.
    - mem_ack and timeout in the same cycle: ack wins, no error.
  - DONE: StallMem=0, the M register loads the next instruction, and the state goes to IDLE unconditionally.
- Latency:
  - Non-memory instruction occupies M for 1 cycle.
  - Memory instruction occupies M for 2 + (cycles in BUSY), i.e. a minimum of 3 with ack on the first BUSY cycle.
- mem_ack outside BUSY is ignored.
- ReadDataM holds its value until the next load capture/abort.
- Back-to-back memops: the second enters IDLE then BUSY; no request overlap.
- Reset mid-BUSY: mem_req drops immediately (async); the transaction is abandoned.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 while BUSY with mem_req=1.
   - Required: mem_req, StallMem, ValidM and MemErrM go to 0 without a clock edge; after release, state is IDLE.
2. ALU op:
   - Stimulus: ValidE=1, RegWriteE=1, ALUOutE=0x0000_002A, WriteRegE=5.
   - Required: next edge gives ValidM=1, ALUOutM=0x2A, WriteRegM=5; StallMem stays 0; mem_req never rises.
3. Load:
   - Stimulus: MemtoRegE=1, ALUOutE=0x100, mem_ack on the 2nd BUSY cycle with mem_rdata=0xDEADBEEF.
   - Required: mem_addr=0x100 and mem_we=0 during req; StallMem=1 for 3 cycles; ReadDataM=0xDEADBEEF; MemErrM=0; next instruction loads the following edge.
4. Store:
   - Stimulus: MemWriteE=1, ALUOutE=0x200, WriteDataE=0x12345678, ack on the 1st BUSY cycle.
   - Required: mem_we=1, mem_wdata=0x12345678, mem_req high exactly 1 cycle; StallMem=1 for 2 cycles.
5. Timeout:
   - Stimulus: TIMEOUT=4, load with no ack.
   - Required: mem_req high 4 cycles then drops; MemErrM=1 and ReadDataM=0 in DONE; MemErrM clears on the next load.
   - Repeat with ack on the 4th BUSY cycle: MemErrM=0 and data is captured.
6. Flush:
   - Stimulus: FlushM=1 with ValidE=1, RegWriteE=1, MemWriteE=1 while StallMem=0.
   - Required: ValidM=0, RegWriteM=0, MemWriteM=0, no request.
   - Also: FlushM=1 during BUSY leaves the M register and mem_req unchanged.
